// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared types and constants for the maze game controller:
//            state codes, VGA colour constants, default lives and a helper
//            that tells whether a state lets a level pointer run.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GRACE = 3'd2,
    ST_PLAY  = 3'd3,
    ST_SCARE = 3'd4,
    ST_WIN   = 3'd5,
    ST_OVER  = 3'd6
  } state_t;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;

  localparam int LIVES_DEFAULT = 3;

  // The pointer of the selected level is released only in these states.
  function automatic logic level_active(input state_t s);
    return (s == ST_GRACE) || (s == ST_PLAY);
  endfunction

endpackage : game_pkg

`default_nettype wire

// File: rtl/game_level_sequencer_if.sv
// ============================================================================
// Module   : game_level_sequencer_if
// Purpose  : Bundles the level-pointer, VGA and control signals exchanged
//            between the game sequencer and its surroundings.
// Ports    : start_btn, video_on, lvlN_inside, lvlN_win, lvlN_rgb  (to seq)
//            move_tick, lvlN_rst, level_sel, lives, state_o, rgb_out (from seq)
//            modport slave  : the sequencer view
//            modport master : the environment view
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface game_level_sequencer_if;

  logic       start_btn;
  logic       video_on;
  logic       lvl1_inside;
  logic       lvl1_win;
  logic       lvl2_inside;
  logic       lvl2_win;
  logic [2:0] lvl1_rgb;
  logic [2:0] lvl2_rgb;

  logic       move_tick;
  logic       lvl1_rst;
  logic       lvl2_rst;
  logic       level_sel;
  logic [2:0] lives;
  logic [2:0] state_o;
  logic [2:0] rgb_out;

  modport slave (
    input  start_btn, video_on,
    input  lvl1_inside, lvl1_win, lvl2_inside, lvl2_win,
    input  lvl1_rgb, lvl2_rgb,
    output move_tick, lvl1_rst, lvl2_rst, level_sel, lives, state_o, rgb_out
  );

  modport master (
    output start_btn, video_on,
    output lvl1_inside, lvl1_win, lvl2_inside, lvl2_win,
    output lvl1_rgb, lvl2_rgb,
    input  move_tick, lvl1_rst, lvl2_rst, level_sel, lives, state_o, rgb_out
  );

endinterface : game_level_sequencer_if

`default_nettype wire

// File: rtl/tick_divider.sv
// ============================================================================
// Module   : tick_divider
// Purpose  : Free-running modulo-TICK_DIV counter producing a one-cycle
//            movement strobe when the count sits at its last value.
// Ports    : clk       in   system clock
//            reset     in   synchronous active-low reset
//            move_tick out  strobe, high while count == TICK_DIV-1
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_divider #(
  parameter int TICK_DIV = 900000
) (
  input  wire logic clk,
  input  wire logic reset,
  output logic      move_tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q + CNT_ONE;
    if (count_q == CNT_LAST) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Decoded from the count so the strobe lines up with count == TICK_DIV-1.
  assign move_tick = (count_q == CNT_LAST);

endmodule : tick_divider

`default_nettype wire

// File: rtl/game_level_sequencer.sv
// ============================================================================
// Module   : game_level_sequencer
// Purpose  : Top-level maze game controller. Sequences start screen, level 1,
//            level 2, scare screen, win screen and game-over; generates the
//            movement tick and per-level pointer resets; tracks lives and
//            muxes the selected level's pixel colour onto the VGA output.
// Ports    : clk    in   system clock
//            reset  in   synchronous active-low reset
//            bus    slave modport of game_level_sequencer_if
//                   (start_btn, video_on, level flags/colours in;
//                    move_tick, level resets, level_sel, lives, state_o,
//                    rgb_out out)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module game_level_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 900000,
  parameter int GRACE_TICKS = 8,
  parameter int SCARE_TICKS = 180,
  parameter int LIVES       = LIVES_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             reset,
  game_level_sequencer_if.slave bus
);

  // Phase counter is shared by GRACE and SCARE; size it for the larger one.
  localparam int PH_MAX = (GRACE_TICKS > SCARE_TICKS) ? GRACE_TICKS : SCARE_TICKS;
  localparam int PW     = $clog2(PH_MAX + 1);

  localparam logic [PW-1:0] GRACE_LAST = PW'(GRACE_TICKS - 1);
  localparam logic [PW-1:0] SCARE_LAST = PW'(SCARE_TICKS - 1);
  localparam logic [PW-1:0] PH_ONE     = PW'(1);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  logic          move_tick;

  state_t        state_q,     state_d;
  logic          level_sel_q, level_sel_d;
  logic [2:0]    lives_q,     lives_d;
  logic [PW-1:0] phase_q,     phase_d;
  logic          start_btn_q;
  logic          lvl1_rst_q,  lvl1_rst_d;
  logic          lvl2_rst_q,  lvl2_rst_d;

  logic          start_edge;
  logic          cur_win;
  logic          cur_inside;
  logic [2:0]    rgb_sel;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk       (clk),
    .reset     (reset),
    .move_tick (move_tick)
  );

  assign start_edge = bus.start_btn & ~start_btn_q;
  assign cur_win    = level_sel_q ? bus.lvl2_win    : bus.lvl1_win;
  assign cur_inside = level_sel_q ? bus.lvl2_inside : bus.lvl1_inside;

  always_comb begin
    state_d     = state_q;
    level_sel_d = level_sel_q;
    lives_d     = lives_q;
    phase_d     = phase_q;

    case (state_q)
      ST_IDLE, ST_WIN, ST_OVER: begin
        if (start_edge) begin
          state_d     = ST_LOAD;
          level_sel_d = 1'b0;
          lives_d     = LIVES_INIT;
        end
      end

      ST_LOAD: begin
        // Clearing the phase here means a tick landing on GRACE entry is
        // not counted toward the grace period.
        state_d = ST_GRACE;
        phase_d = '0;
      end

      ST_GRACE: begin
        if (move_tick) begin
          if (phase_q == GRACE_LAST) begin
            state_d = ST_PLAY;
          end else begin
            phase_d = phase_q + PH_ONE;
          end
        end
      end

      ST_PLAY: begin
        // Reaching the goal wins over leaving the path in the same cycle.
        if (cur_win) begin
          if (!level_sel_q) begin
            state_d     = ST_LOAD;
            level_sel_d = 1'b1;
          end else begin
            state_d = ST_WIN;
          end
        end else if (!cur_inside) begin
          state_d = ST_SCARE;
          phase_d = '0;
          if (lives_q != 3'd0) begin
            lives_d = lives_q - 3'd1;
          end
        end
      end

      ST_SCARE: begin
        if (move_tick) begin
          if (phase_q == SCARE_LAST) begin
            state_d = (lives_q == 3'd0) ? ST_OVER : ST_LOAD;
          end else begin
            phase_d = phase_q + PH_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered from the next state so the resets change together with it.
    lvl1_rst_d = ~(level_active(state_d) & ~level_sel_d);
    lvl2_rst_d = ~(level_active(state_d) &  level_sel_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      level_sel_q <= 1'b0;
      lives_q     <= LIVES_INIT;
      phase_q     <= '0;
      start_btn_q <= 1'b0;
      lvl1_rst_q  <= 1'b1;
      lvl2_rst_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      level_sel_q <= level_sel_d;
      lives_q     <= lives_d;
      phase_q     <= phase_d;
      start_btn_q <= bus.start_btn;
      lvl1_rst_q  <= lvl1_rst_d;
      lvl2_rst_q  <= lvl2_rst_d;
    end
  end

  always_comb begin
    rgb_sel = BLACK;
    if (bus.video_on) begin
      case (state_q)
        ST_GRACE, ST_PLAY: rgb_sel = level_sel_q ? bus.lvl2_rgb : bus.lvl1_rgb;
        ST_SCARE:          rgb_sel = RED;
        ST_WIN:            rgb_sel = GREEN;
        default:           rgb_sel = BLACK;
      endcase
    end
  end

  assign bus.move_tick = move_tick;
  assign bus.lvl1_rst  = lvl1_rst_q;
  assign bus.lvl2_rst  = lvl2_rst_q;
  assign bus.level_sel = level_sel_q;
  assign bus.lives     = lives_q;
  assign bus.state_o   = state_q;
  assign bus.rgb_out   = rgb_sel;

endmodule : game_level_sequencer

`default_nettype wire

// File: doc/game_level_sequencer.md
Name: game_level_sequencer

Overview:
Top-level game controller for the maze game. It sequences start screen, level 1, level 2, scare screen, win screen and game-over. It generates the movement tick and the per-level pointer resets, and tracks lives. It consumes each level pointer's "inside path" and "win zone" flags and selects which level's pixel colour reaches the VGA output.

Parameters:
TICK_DIV, 900000, clk cycles per movement tick; must be ≥2.
GRACE_TICKS, 8, movement ticks after level load during which path flags are ignored.
SCARE_TICKS, 180, movement ticks the scare screen is held.
LIVES, 3, lives at game start; range 1..7.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
start_btn  in  1  debounced start/restart button, level-sensitive
video_on  in  1  VGA visible-area flag
lvl1_inside  in  1  level-1 pointer fully inside path
lvl1_win  in  1  level-1 pointer in goal zone
lvl2_inside  in  1  level-2 pointer fully inside path
lvl2_win  in  1  level-2 pointer in goal zone
lvl1_rgb  in  3  level-1 pixel colour
lvl2_rgb  in  3  level-2 pixel colour
move_tick  out  1  one-cycle movement strobe to pointer modules
lvl1_rst  out  1  active-high reset to level-1 pointer
lvl2_rst  out  1  active-high reset to level-2 pointer
level_sel  out  1  0 = level 1, 1 = level 2
lives  out  3  remaining lives
state_o  out  3  current state code, for debug and LEDs
rgb_out  out  3  final pixel colour

Behaviour:
- Reset values:
  - state IDLE, level_sel 0, lives LIVES.
  - Divider count 0, move_tick 0.
  - lvl1_rst and lvl2_rst both 1.
  - start_btn edge register 0, phase counter 0.
- Divider:
  - Free-running 0..TICK_DIV-1.
  - move_tick=1 for exactly the cycle in which count==TICK_DIV-1; 0 otherwise.
  - Cleared only by reset.
- start_edge = start_btn & ~start_btn_q, where start_btn_q is registered every cycle.
- State codes: IDLE=0, LOAD=1, GRACE=2, PLAY=3, SCARE=4, WIN=5, OVER=6.
- Transitions:
  - IDLE: start_edge → LOAD; level_sel←0, lives←LIVES.
  - LOAD: exactly 1 cycle → GRACE; phase counter←0.
  - GRACE: on each move_tick the counter increments. When the counter reaches GRACE_TICKS-1 on a move_tick → PLAY. inside/win flags are ignored.
  - PLAY: the flags for the selected level are sampled every cycle.
    - win=1, level_sel=0 → LOAD with level_sel←1.
    - win=1, level_sel=1 → WIN.
    - else inside=0 → SCARE; lives←lives-1; counter←0.
    - If win and ~inside occur in the same cycle, win takes priority.
  - SCARE: counts SCARE_TICKS move_ticks. On completion: lives==0 → OVER, else → LOAD with level_sel unchanged.
  - WIN, OVER: start_edge → LOAD; level_sel←0, lives←LIVES.
- lives saturates at 0 and never wraps.
- Level resets (registered, derived from next state):
  - lvlN_rst=0 only while state ∈ {GRACE, PLAY} and level_sel selects N.
  - lvlN_rst=1 otherwise, so the pointer is held at its start position in LOAD, SCARE, IDLE, WIN and OVER.
- rgb_out is combinational from registered state:
  - video_on=0 → 000.
  - GRACE/PLAY → selected lvlN_rgb.
  - SCARE → 100.
  - WIN → 010.
  - IDLE/OVER → 000.
- A move_tick coinciding with a state entry is not counted toward the new state's phase.
- Reset asserted mid-game returns all registers to reset values on the next clk edge, regardless of state.

Decomposition:
- Shared package game_pkg:
  - state codes.
  - colour constants: BLACK=000, RED=100, GREEN=010.
  - default LIVES.
- One sub-module, tick_divider (parameter TICK_DIV; ports clk, reset, move_tick), reused by the pointer levels.

Test Plan:
All scenarios use TICK_DIV=4, GRACE_TICKS=2, SCARE_TICKS=3, LIVES=2.
1. Reset held low 5 cycles, then high:
   - state_o=0, lives=2, lvl1_rst=lvl2_rst=1, rgb_out=000.
   - move_tick pulses every 4th cycle.
2. start_btn held high 20 cycles:
   - Exactly one LOAD (state_o=1 for 1 cycle), then GRACE.
   - PLAY after 2 ticks; lvl1_rst=0, level_sel=0.
   - No second restart while the button stays high.
3. In PLAY, drive lvl1_inside=0 with video_on=1:
   - state_o=4, lives=1, rgb_out=100, lvl1_rst=1.
   - After 3 ticks, LOAD again with level_sel=0.
4. Second exit while lives=1:
   - lives=0, SCARE for 3 ticks, then OVER (state_o=6).
   - start_edge → LOAD with lives=2, level_sel=0.
5. In PLAY level 1, assert lvl1_win=1 with lvl1_inside=0 in the same cycle:
   - LOAD with level_sel=1; lives unchanged.
   - Then lvl2_win=1 in PLAY → WIN, rgb_out=010 when video_on=1 and 000 when video_on=0.
6. Reset asserted low during SCARE:
   - Next cycle state_o=0, lives=2, both level resets=1, divider count restarts from 0.
